uart_frame_rx: RTL and testbench

Frame deframer sitting directly downstream of the UART receiver. It consumes the byte stream from `rx_data`/`rx_data_valid`/`rx_data_ready` and recognises frames of the form header 0xA5, LEN, LEN payload bytes, CHK. It buffers the payload internally and releases it on a valid/ready byte stream only when the checksum matches. Malformed, corrupted or stalled frames are dropped and flagged with an error pulse.

---
 rtl/uart_frame_rx_if.sv | 25 ++
 rtl/uart_frame_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_rx_if.sv
// Byte-stream bundle between the UART receiver, the frame deframer and its consumer.
// master = environment side (drives input bytes and out_ready), slave = deframer side.
// Carries the input handshake, the payload output handshake and the frame status pulses.
interface uart_frame_rx_if;
  logic [7:0] in_data;
  logic       in_data_valid;
  logic       in_data_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  modport master (
    output in_data, in_data_valid, out_ready,
    input  in_data_ready, out_data, out_valid, out_last, frame_ok, frame_err, err_code
  );

  modport slave (
    input  in_data, in_data_valid, out_ready,
    output in_data_ready, out_data, out_valid, out_last, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/uart_frame_rx.sv
// Frame deframer (A5, LEN, payload, XOR CHK): buffers payload, releases it only when the checksum matches.
// Latency: first payload byte and frame_ok appear the cycle after CHK is accepted; then 1 byte/cycle.
// Backpressure: out_ready stalls the output stream; in_data_ready drops for the whole output phase.
module uart_frame_rx #(
  parameter int CLK_FRE       = 50,
  parameter int BAUD_RATE     = 115200,
  parameter int MAX_LEN       = 16,
  parameter int TIMEOUT_BYTES = 4
) (
  input logic            clk,
  input logic            rst_n,
  uart_frame_rx_if.slave fr
);

  localparam longint TIMEOUT_L = (longint'(TIMEOUT_BYTES) * 64'd10 * longint'(CLK_FRE) * 64'd1000000)
                                 / longint'(BAUD_RATE);
  localparam int TIMEOUT = (TIMEOUT_L < 2) ? 2 : int'(TIMEOUT_L);
  localparam int CW      = $clog2(TIMEOUT + 1);
  localparam int IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {S_HDR, S_LEN, S_PAY, S_CHK, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      csum_q, csum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            frame_ok_q, frame_ok_d;
  logic            frame_err_q, frame_err_d;
  logic [1:0]      err_code_q, err_code_d;

  logic [7:0]      buf_q [MAX_LEN];

  logic            acc;
  logic            in_frame;
  logic            tmo;
  logic [IW-1:0]   idx_nxt;

  assign fr.in_data_ready = (state_q != S_OUT);
  assign acc      = fr.in_data_valid && fr.in_data_ready;
  assign in_frame = (state_q == S_LEN) || (state_q == S_PAY) || (state_q == S_CHK);
  // An accepted byte in the expiry cycle takes priority over the timeout.
  assign tmo      = in_frame && !acc && (cnt_q == CW'(TIMEOUT - 1));
  assign idx_nxt  = idx_q + IW'(1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      S_HDR: begin
        if (acc && fr.in_data == 8'hA5) state_d = S_LEN;
      end

      S_LEN: begin
        if (acc) begin
          if (fr.in_data == 8'd0 || int'(fr.in_data) > MAX_LEN) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
            state_d     = S_HDR;
          end else begin
            len_d   = fr.in_data;
            csum_d  = fr.in_data;
            idx_d   = '0;
            state_d = S_PAY;
          end
        end else if (tmo) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
          state_d     = S_HDR;
        end
      end

      S_PAY: begin
        if (acc) begin
          csum_d = csum_q ^ fr.in_data;
          idx_d  = idx_nxt;
          if (8'(idx_q) == len_q - 8'd1) state_d = S_CHK;
        end else if (tmo) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
          state_d     = S_HDR;
        end
      end

      S_CHK: begin
        if (acc) begin
          if (fr.in_data == csum_q) begin
            frame_ok_d  = 1'b1;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = buf_q[0];
            out_last_d  = (len_q == 8'd1);
            state_d     = S_OUT;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
            state_d     = S_HDR;
          end
        end else if (tmo) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
          state_d     = S_HDR;
        end
      end

      S_OUT: begin
        if (out_valid_q && fr.out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            idx_d       = '0;
            state_d     = S_HDR;
          end else begin
            idx_d      = idx_nxt;
            out_data_d = buf_q[idx_nxt];
            out_last_d = (8'(idx_nxt) == len_q - 8'd1);
          end
        end
      end

      default: state_d = S_HDR;
    endcase
  end

  // Inter-byte timer restarts on every accepted byte and every state change.
  always_comb begin
    cnt_d = '0;
    if (in_frame && !acc && (state_d == state_q)) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HDR;
      len_q       <= '0;
      csum_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Payload storage needs no reset: it is always written before it is read.
  always_ff @(posedge clk) begin
    if (acc && state_q == S_PAY) buf_q[idx_q] <= fr.in_data;
  end

  assign fr.out_data  = out_data_q;
  assign fr.out_valid = out_valid_q;
  assign fr.out_last  = out_last_q;
  assign fr.frame_ok  = frame_ok_q;
  assign fr.frame_err = frame_err_q;
  assign fr.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx at default parameters (MAX_LEN=16, timeout 17361 cycles).
module tb_uart_frame_rx;
  localparam int TIMEOUT_CYC = 17361;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_frame_rx_if fr();

  uart_frame_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fr    (fr)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  logic [8:0] outq [$];
  logic [1:0] errq [$];
  int ok_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;
  int last_acc_cyc = 0, last_err_cyc = 0, last_ok_cyc = 0, first_vld_cyc = 0;
  logic prev_vld = 1'b0;

  // Mid-cycle observer: inputs change just after posedge, so negedge values hold through the next edge.
  always @(negedge clk) begin
    if (fr.in_data_valid && fr.in_data_ready) begin
      acc_cnt++;
      last_acc_cyc = cyc + 1;
    end
    if (fr.frame_ok) begin
      ok_cnt++;
      last_ok_cyc = cyc;
    end
    if (fr.frame_err) begin
      err_cnt++;
      errq.push_back(fr.err_code);
      last_err_cyc = cyc;
    end
    if (fr.frame_ok && fr.frame_err) both_cnt++;
    if (fr.out_valid && !prev_vld) first_vld_cyc = cyc;
    prev_vld = fr.out_valid;
    if (fr.out_valid && fr.out_ready) outq.push_back({fr.out_last, fr.out_data});
  end

  task automatic send(input logic [7:0] b);
    int n;
    fr.in_data = b;
    fr.in_data_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!fr.in_data_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL send_stall byte %h never accepted", b);
    end
    @(posedge clk);
    #1;
    fr.in_data_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] b [8], input int n);
    for (int i = 0; i < n; i++) send(b[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_short_good();
    send_seq('{0: 8'hA5, 1: 8'h01, 2: 8'h7E, 3: 8'h7F, default: 8'h00}, 4);
  endtask

  task automatic test_reset();
    fr.in_data = 8'h00;
    fr.in_data_valid = 1'b0;
    fr.out_ready = 1'b1;
    rst_n = 1'b0;
    idle(3);
    @(negedge clk);
    vectors++; if (fr.in_data_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", fr.in_data_ready); end
    vectors++; if (fr.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", fr.out_valid); end
    vectors++; if (fr.out_last !== 1'b0) begin miscompares++; $display("FAIL rst_out_last got %b want 0", fr.out_last); end
    vectors++; if (fr.frame_ok !== 1'b0 || fr.frame_err !== 1'b0) begin miscompares++; $display("FAIL rst_pulses got ok=%b err=%b want 0 0", fr.frame_ok, fr.frame_err); end
    vectors++; if (fr.out_data !== 8'h00 || fr.err_code !== 2'd0) begin miscompares++; $display("FAIL rst_data got data=%h code=%0d want 00 0", fr.out_data, fr.err_code); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    int o0, ok0, e0, chk;
    o0 = outq.size(); ok0 = ok_cnt; e0 = err_cnt;
    send_seq('{0: 8'hA5, 1: 8'h03, 2: 8'h11, 3: 8'h22, 4: 8'h33, 5: 8'h03, default: 8'h00}, 6);
    chk = last_acc_cyc;
    idle(8);
    vectors++; if (ok_cnt - ok0 !== 1) begin miscompares++; $display("FAIL good_ok_count got %0d want 1", ok_cnt - ok0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL good_err_count got %0d want 0", err_cnt - e0); end
    vectors++; if (outq.size() - o0 !== 3) begin miscompares++; $display("FAIL good_out_count got %0d want 3", outq.size() - o0); end
    if (outq.size() - o0 >= 3) begin
      vectors++; if (outq[o0] !== 9'h011) begin miscompares++; $display("FAIL good_byte0 got %h want 011", outq[o0]); end
      vectors++; if (outq[o0+1] !== 9'h022) begin miscompares++; $display("FAIL good_byte1 got %h want 022", outq[o0+1]); end
      vectors++; if (outq[o0+2] !== 9'h133) begin miscompares++; $display("FAIL good_byte2 got %h want 133", outq[o0+2]); end
    end
    vectors++; if (first_vld_cyc !== chk) begin miscompares++; $display("FAIL good_vld_latency got cycle %0d want %0d", first_vld_cyc, chk); end
    vectors++; if (last_ok_cyc !== chk) begin miscompares++; $display("FAIL good_ok_latency got cycle %0d want %0d", last_ok_cyc, chk); end
  endtask

  task automatic test_bad_checksum();
    int o0, ok0, e0;
    o0 = outq.size(); ok0 = ok_cnt; e0 = err_cnt;
    send_seq('{0: 8'hA5, 1: 8'h03, 2: 8'h11, 3: 8'h22, 4: 8'h33, 5: 8'h04, default: 8'h00}, 6);
    idle(4);
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL badchk_err_count got %0d want 1", err_cnt - e0); end
    if (errq.size() > 0) begin
      vectors++; if (errq[errq.size()-1] !== 2'd2) begin miscompares++; $display("FAIL badchk_code got %0d want 2", errq[errq.size()-1]); end
    end
    vectors++; if (outq.size() - o0 !== 0 || ok_cnt - ok0 !== 0) begin miscompares++; $display("FAIL badchk_no_output got out=%0d ok=%0d want 0 0", outq.size() - o0, ok_cnt - ok0); end
    send_short_good();
    idle(4);
    vectors++; if (outq.size() - o0 !== 1) begin miscompares++; $display("FAIL badchk_follow_count got %0d want 1", outq.size() - o0); end
    if (outq.size() - o0 >= 1) begin
      vectors++; if (outq[o0] !== 9'h17E) begin miscompares++; $display("FAIL badchk_follow_byte got %h want 17E", outq[o0]); end
    end
    vectors++; if (ok_cnt - ok0 !== 1) begin miscompares++; $display("FAIL badchk_follow_ok got %0d want 1", ok_cnt - ok0); end
  endtask

  task automatic test_bad_length();
    int o0, ok0, e0, q0;
    o0 = outq.size(); ok0 = ok_cnt; e0 = err_cnt; q0 = errq.size();
    send_seq('{0: 8'hA5, 1: 8'h00, 2: 8'hA5, 3: 8'h11, default: 8'h00}, 4);
    idle(4);
    vectors++; if (err_cnt - e0 !== 2) begin miscompares++; $display("FAIL badlen_err_count got %0d want 2", err_cnt - e0); end
    if (errq.size() - q0 >= 2) begin
      vectors++; if (errq[q0] !== 2'd1) begin miscompares++; $display("FAIL badlen_code0 got %0d want 1", errq[q0]); end
      vectors++; if (errq[q0+1] !== 2'd1) begin miscompares++; $display("FAIL badlen_code1 got %0d want 1", errq[q0+1]); end
    end
    send_short_good();
    idle(4);
    vectors++; if (outq.size() - o0 !== 1 || ok_cnt - ok0 !== 1) begin miscompares++; $display("FAIL badlen_follow got out=%0d ok=%0d want 1 1", outq.size() - o0, ok_cnt - ok0); end
    if (outq.size() - o0 >= 1) begin
      vectors++; if (outq[o0] !== 9'h17E) begin miscompares++; $display("FAIL badlen_follow_byte got %h want 17E", outq[o0]); end
    end
  endtask

  task automatic test_garbage();
    int o0, ok0, e0;
    o0 = outq.size(); ok0 = ok_cnt; e0 = err_cnt;
    send_seq('{0: 8'h00, 1: 8'hFF, 2: 8'h5A, 3: 8'hA5, 4: 8'h01, 5: 8'h7E, 6: 8'h7F, default: 8'h00}, 7);
    idle(4);
    vectors++; if (ok_cnt - ok0 !== 1) begin miscompares++; $display("FAIL garbage_ok got %0d want 1", ok_cnt - ok0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL garbage_err got %0d want 0", err_cnt - e0); end
    vectors++; if (outq.size() - o0 !== 1) begin miscompares++; $display("FAIL garbage_out_count got %0d want 1", outq.size() - o0); end
    if (outq.size() - o0 >= 1) begin
      vectors++; if (outq[o0] !== 9'h17E) begin miscompares++; $display("FAIL garbage_byte got %h want 17E", outq[o0]); end
    end
  endtask

  task automatic test_timeout();
    int o0, ok0, e0, n, acc_at;
    o0 = outq.size(); ok0 = ok_cnt; e0 = err_cnt;
    send_seq('{0: 8'hA5, 1: 8'h02, 2: 8'h11, default: 8'h00}, 3);
    acc_at = last_acc_cyc;
    n = 0;
    while (err_cnt == e0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1;
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL timeout_err_count got %0d want 1", err_cnt - e0); end
    vectors++; if (last_err_cyc - acc_at !== TIMEOUT_CYC) begin miscompares++; $display("FAIL timeout_delay got %0d want %0d", last_err_cyc - acc_at, TIMEOUT_CYC); end
    if (errq.size() > 0) begin
      vectors++; if (errq[errq.size()-1] !== 2'd3) begin miscompares++; $display("FAIL timeout_code got %0d want 3", errq[errq.size()-1]); end
    end
    idle(2);
    send_short_good();
    idle(4);
    vectors++; if (outq.size() - o0 !== 1 || ok_cnt - ok0 !== 1) begin miscompares++; $display("FAIL timeout_follow got out=%0d ok=%0d want 1 1", outq.size() - o0, ok_cnt - ok0); end
    if (outq.size() - o0 >= 1) begin
      vectors++; if (outq[o0] !== 9'h17E) begin miscompares++; $display("FAIL timeout_follow_byte got %h want 17E", outq[o0]); end
    end
  endtask

  task automatic test_back_pressure();
    int o0, ok0, a0, n;
    o0 = outq.size(); ok0 = ok_cnt;
    fr.out_ready = 1'b0;
    send_seq('{0: 8'hA5, 1: 8'h03, 2: 8'h11, 3: 8'h22, 4: 8'h33, 5: 8'h03, default: 8'h00}, 6);
    fr.in_data = 8'hA5;
    fr.in_data_valid = 1'b1;
    a0 = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++; if (fr.in_data_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready cyc%0d got %b want 0", i, fr.in_data_ready); end
      vectors++; if (fr.out_valid !== 1'b1 || fr.out_data !== 8'h11 || fr.out_last !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold cyc%0d got v=%b d=%h l=%b want 1 11 0", i, fr.out_valid, fr.out_data, fr.out_last);
      end
    end
    vectors++; if (acc_cnt !== a0) begin miscompares++; $display("FAIL bp_no_consume got %0d accepts want 0", acc_cnt - a0); end
    @(posedge clk);
    #1;
    fr.out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!fr.in_data_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL bp_ready_return got %0d cycles want 3", n); end
    @(posedge clk);
    #1;
    fr.in_data_valid = 1'b0;
    send_seq('{0: 8'h01, 1: 8'h7E, 2: 8'h7F, default: 8'h00}, 3);
    idle(4);
    vectors++; if (outq.size() - o0 !== 4) begin miscompares++; $display("FAIL bp_out_count got %0d want 4", outq.size() - o0); end
    if (outq.size() - o0 >= 4) begin
      vectors++; if (outq[o0] !== 9'h011 || outq[o0+1] !== 9'h022 || outq[o0+2] !== 9'h133) begin
        miscompares++; $display("FAIL bp_frame1 got %h %h %h want 011 022 133", outq[o0], outq[o0+1], outq[o0+2]);
      end
      vectors++; if (outq[o0+3] !== 9'h17E) begin miscompares++; $display("FAIL bp_frame2 got %h want 17E", outq[o0+3]); end
    end
    vectors++; if (ok_cnt - ok0 !== 2) begin miscompares++; $display("FAIL bp_ok_count got %0d want 2", ok_cnt - ok0); end
  endtask

  task automatic test_reset_mid_frame();
    int o0, ok0, e0;
    send_seq('{0: 8'hA5, 1: 8'h04, 2: 8'h11, 3: 8'h22, default: 8'h00}, 4);
    o0 = outq.size(); ok0 = ok_cnt; e0 = err_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (fr.in_data_ready !== 1'b1 || fr.out_valid !== 1'b0 || fr.out_last !== 1'b0) begin
      miscompares++; $display("FAIL midrst_outs got rdy=%b v=%b l=%b want 1 0 0", fr.in_data_ready, fr.out_valid, fr.out_last);
    end
    vectors++; if (fr.out_data !== 8'h00 || fr.err_code !== 2'd0) begin miscompares++; $display("FAIL midrst_data got %h %0d want 00 0", fr.out_data, fr.err_code); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    vectors++; if (ok_cnt - ok0 !== 0 || err_cnt - e0 !== 0) begin miscompares++; $display("FAIL midrst_pulses got ok=%0d err=%0d want 0 0", ok_cnt - ok0, err_cnt - e0); end
    send_short_good();
    idle(4);
    vectors++; if (outq.size() - o0 !== 1 || ok_cnt - ok0 !== 1) begin miscompares++; $display("FAIL midrst_follow got out=%0d ok=%0d want 1 1", outq.size() - o0, ok_cnt - ok0); end
    if (outq.size() - o0 >= 1) begin
      vectors++; if (outq[o0] !== 9'h17E) begin miscompares++; $display("FAIL midrst_follow_byte got %h want 17E", outq[o0]); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_garbage();
    test_timeout();
    test_back_pressure();
    test_reset_mid_frame();
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL ok_err_overlap got %0d cycles want 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
